// File: rtl/spi_flash_reader.sv
// Sequences a serial-flash READ frame (command, address, filler) into spi_master
// and forwards only payload bytes. Define FAST_READ_EN for 0x0B plus one dummy byte.
module spi_flash_reader #(
  parameter int         ADDR_W = 24,
  parameter int         LEN_W  = 8,
  parameter logic [7:0] FILL   = 8'hFF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [7:0]        m_data,
  input  logic              m_get,
  output logic              m_empty,
  input  logic [7:0]        m_out,
  input  logic              m_put,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte moves to spi_master on a cycle with m_get=1 and m_empty=0;
  // the following byte is on m_data one cycle later. Each m_put delivers one
  // received byte; rd_valid is a single-cycle strobe with no backpressure.

  localparam int NAB = ADDR_W / 8;
`ifdef FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
  localparam int         HDR      = 2 + NAB;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
  localparam int         HDR      = 1 + NAB;
`endif
  localparam int CW  = LEN_W + 1;
  localparam int RXW = $clog2(HDR + (1 << LEN_W) + 1);
  localparam logic [RXW-1:0] HDR_R = RXW'(HDR);
  localparam logic [CW-1:0]  LAST_ADDR_IDX = CW'(NAB - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
`ifdef FAST_READ_EN
    S_DUMMY = 3'd5,
`endif
    S_FILL  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RXW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [7:0]        m_data_q, m_data_d;
  logic              m_empty_q, m_empty_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic              consume;
  logic [RXW-1:0]    frame_len;

  assign consume   = m_get && !m_empty_q;
  assign frame_len = HDR_R + RXW'(len_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rx_cnt_d   = rx_cnt_q;
    m_data_d   = m_data_q;
    m_empty_d  = m_empty_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    // Received bytes: the first HDR are echoes of the header and are dropped.
    if (busy_q && m_put) begin
      rx_cnt_d = rx_cnt_q + RXW'(1);
      if (rx_cnt_q >= HDR_R) begin
        rd_data_d  = m_out;
        rd_valid_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = addr;
          len_d     = {(len == '0), len};  // len=0 encodes 2^LEN_W
          cnt_d     = '0;
          rx_cnt_d  = '0;
          m_data_d  = CMD_BYTE;
          m_empty_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (consume) begin
          m_data_d = addr_q[ADDR_W-1 -: 8];
          addr_d   = addr_q << 8;
          cnt_d    = '0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (consume) begin
          if (cnt_q == LAST_ADDR_IDX) begin
            m_data_d = FILL;
            cnt_d    = '0;
`ifdef FAST_READ_EN
            state_d  = S_DUMMY;
`else
            state_d  = S_FILL;
`endif
          end else begin
            m_data_d = addr_q[ADDR_W-1 -: 8];
            addr_d   = addr_q << 8;
            cnt_d    = cnt_q + CW'(1);
          end
        end
      end
`ifdef FAST_READ_EN
      S_DUMMY: begin
        if (consume) begin
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
`endif
      S_FILL: begin
        if (consume) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == len_q) begin
            m_empty_d = 1'b1;
            // A zero-latency master can deliver the final echo in this same cycle.
            if (rx_cnt_d == frame_len) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (rx_cnt_d == frame_len) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        m_empty_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rx_cnt_q   <= '0;
      m_data_q   <= '0;
      m_empty_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      m_data_q   <= m_data_d;
      m_empty_q  <= m_empty_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign m_data    = m_data_q;
  assign m_empty   = m_empty_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural spi_master/flash stand-in with adjustable
// latency, scoreboard queues for transmitted bytes, payload bytes and done pulses.
`timescale 1ns/1ps
module tb_spi_flash_reader;

  localparam logic [7:0] FILL_B = 8'hFF;
`ifdef FAST_READ_EN
  localparam logic [7:0] CMD_B = 8'h0B;
  localparam int         H_B   = 5;
`else
  localparam logic [7:0] CMD_B = 8'h03;
  localparam int         H_B   = 4;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [23:0] addr    = '0;
  logic [7:0]  len     = '0;
  logic        m_get   = 1'b0;
  logic        m_put   = 1'b0;
  logic [7:0]  m_out   = '0;
  logic        busy, done, m_empty, rd_valid;
  logic [7:0]  m_data, rd_data;
  logic [2:0]  dbg_state;

  always #5 clock = ~clock;

  spi_flash_reader dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .addr     (addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .m_data   (m_data),
    .m_get    (m_get),
    .m_empty  (m_empty),
    .m_out    (m_out),
    .m_put    (m_put),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_tx_q[$];
  int         done_exp  = 0;
  int         idx       = 0;
  int         lat       = 1;
  int         gap       = 0;
  bit         echo_mode = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'd0:   return 8'hAA;
      24'd1:   return 8'hBB;
      24'd2:   return 8'hCC;
      default: return a[7:0] ^ 8'h5C;
    endcase
  endfunction

  // ---------------- spi_master + flash stand-in ----------------
  initial begin : master
    logic [7:0]  b;
    logic [7:0]  resp;
    logic [23:0] fa;
    fa = '0;
    forever begin
      @(negedge clock);
      m_get = 1'b0;
      m_put = 1'b0;
      if (!reset_n || m_empty) begin
        idx = 0;
      end else begin
        repeat (gap) @(negedge clock);
        if (reset_n && !m_empty) begin
          b = m_data;
          if (exp_tx_q.size() == 0) fail_now("tx_unexpected", 32'(b));
          else check("tx_byte", 32'(b), 32'(exp_tx_q.pop_front()));
          if (idx == 0) fa = '0;
          if (idx >= 1 && idx <= 3) fa = {fa[15:0], b};
          if (idx < H_B) resp = echo_mode ? b : (8'hE0 | 8'(idx));
          else           resp = echo_mode ? b : mem_byte(fa + 24'(idx - H_B));
          m_get = 1'b1;
          if (lat == 0) begin
            m_put = 1'b1;
            m_out = resp;
          end
          @(negedge clock);
          m_get = 1'b0;
          m_put = 1'b0;
          if (lat > 0) begin
            repeat (lat - 1) @(negedge clock);
            m_put = 1'b1;
            m_out = resp;
            @(negedge clock);
            m_put = 1'b0;
          end
          idx++;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (rd_valid) begin
        if (exp_q.size() == 0) fail_now("rd_unexpected", 32'(rd_data));
        else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
      if (done) begin
        if (done_exp == 0) fail_now("done_unexpected", 32'(1));
        else begin
          check("done_after_payload", 32'(exp_q.size()), 32'(0));
          done_exp--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic arm_frame(input logic [23:0] a, input logic [7:0] l, input int lt,
                           input int gp, input bit echo);
    int n;
    lat       = lt;
    gap       = gp;
    echo_mode = echo;
    n = (l == 8'd0) ? 256 : int'(l);
    exp_tx_q.push_back(CMD_B);
    exp_tx_q.push_back(a[23:16]);
    exp_tx_q.push_back(a[15:8]);
    exp_tx_q.push_back(a[7:0]);
`ifdef FAST_READ_EN
    exp_tx_q.push_back(FILL_B);
`endif
    for (int j = 0; j < n; j++) begin
      exp_tx_q.push_back(FILL_B);
      exp_q.push_back(echo ? FILL_B : mem_byte(a + 24'(j)));
    end
    done_exp++;
  endtask

  task automatic pulse_start(input logic [23:0] a, input logic [7:0] l);
    @(negedge clock);
    start = 1'b1;
    addr  = a;
    len   = l;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(1));
  endtask

  task automatic run_frame(input logic [23:0] a, input logic [7:0] l, input int lt,
                           input int gp, input bit echo, input bit poke);
    int cyc;
    bit got;
    bit dropped;
    arm_frame(a, l, lt, gp, echo);
    pulse_start(a, l);
    cyc = 0; got = 1'b0; dropped = 1'b0;
    while (!got && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      if (done) got = 1'b1;
      else if (!busy) dropped = 1'b1;
      if (poke && cyc == 6) begin
        start = 1'b1;
        addr  = 24'hABCDEF;
        len   = 8'd5;
      end
      if (poke && cyc == 7) start = 1'b0;
    end
    if (!got) begin
      fail_now("done_timeout", 32'(cyc));
      exp_q.delete();
      exp_tx_q.delete();
      done_exp = 0;
    end
    check("busy_held", 32'(dropped), 32'(0));
    @(negedge clock);
    check("m_empty_after", 32'(m_empty), 32'(1));
    check("busy_after", 32'(busy), 32'(0));
    check("done_one_cycle", 32'(done), 32'(0));
    repeat (20) @(negedge clock);
    check("tx_all_sent", 32'(exp_tx_q.size()), 32'(0));
    check("rd_all_seen", 32'(exp_q.size()), 32'(0));
    check("done_count", 32'(done_exp), 32'(0));
  endtask

  task automatic reset_mid_frame;
    int cyc;
    arm_frame(24'h123456, 8'd2, 2, 1, 1'b1);
    pulse_start(24'h123456, 8'd2);
    cyc = 0;
    while (idx < 2 && cyc < 200) begin
      @(posedge clock);
      cyc++;
    end
    if (idx < 2) fail_now("addr_phase_timeout", 32'(cyc));
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_m_empty", 32'(m_empty), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rd_valid", 32'(rd_valid), 32'(0));
    exp_q.delete();
    exp_tx_q.delete();
    done_exp = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("rst_idle_busy", 32'(busy), 32'(0));
    check("rst_idle_m_empty", 32'(m_empty), 32'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    repeat (3) @(negedge clock);
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_m_empty", 32'(m_empty), 32'(1));
    check("reset_m_data", 32'(m_data), 32'(0));
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_done", 32'(done), 32'(0));
    check("idle_rd_data", 32'(rd_data), 32'(0));
    check("idle_rd_valid", 32'(rd_valid), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));

    run_frame(24'h123456, 8'd2, 1, 0, 1'b1, 1'b0);  // echo loopback
    run_frame(24'h000000, 8'd3, 0, 0, 1'b0, 1'b0);  // flash AA,BB,CC, zero latency
    run_frame(24'h000100, 8'd0, 0, 0, 1'b0, 1'b0);  // 256-byte payload
    run_frame(24'hFEDCBA, 8'd4, 2, 1, 1'b0, 1'b1);  // start pulsed while busy
    reset_mid_frame();
    run_frame(24'h000010, 8'd1, 1, 2, 1'b1, 1'b0);  // clean frame after reset
    run_frame(24'hFFFFFD, 8'd5, 3, 0, 1'b0, 1'b0);  // address wrap, slow master

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
